// File: rtl/prio_irq_encoder_pkg.sv
// prio_irq_encoder_pkg: shared FSM state encoding and width helper
package prio_irq_encoder_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/prio_irq_encoder_pick.sv
// prio_irq_encoder_pick: finds the highest-priority set bit, optionally rotated below a start index
module prio_irq_encoder_pick
    import prio_irq_encoder_pkg::*;
#(
    parameter  int N_REQ = 8,
    localparam int IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_vec,
    input  logic [IDX_W-1:0] i_start_idx,
    input  logic             i_rr_en,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    int               w_start;
    int               w_j;
    logic [IDX_W-1:0] w_jx;

    // Walk from start-1 downward with wrap; start 0 degenerates to plain highest-index-wins
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_start = i_rr_en ? int'(i_start_idx) : 0;
        w_j     = 0;
        w_jx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_j  = (w_start + 2 * N_REQ - 1 - k) % N_REQ;
            w_jx = IDX_W'(w_j);
            if (!o_found && i_vec[w_jx]) begin
                o_found = 1'b1;
                o_idx   = w_jx;
            end
        end
    end

endmodule

// File: rtl/prio_irq_encoder.sv
// prio_irq_encoder: sticky pending latches feeding a registered priority winner with valid/ack handshake
module prio_irq_encoder
    import prio_irq_encoder_pkg::*;
#(
    parameter  int N_REQ     = 8,
    parameter  int EDGE_MODE = 0,
    parameter  int RR_MODE   = 0,
    localparam int CODE_W    = clog2(N_REQ + 1),
    localparam int IDX_W     = clog2(N_REQ)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_REQ-1:0]  i_req,
    input  logic [N_REQ-1:0]  i_mask,
    input  logic              i_irq_ack,
    output logic              o_irq_valid,
    output logic [CODE_W-1:0] o_irq_code,
    output logic [N_REQ-1:0]  o_pending,
    output logic              o_irq_lost
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic                r_valid;
    logic                w_valid_nxt;
    logic [CODE_W-1:0]   r_code;
    logic [CODE_W-1:0]   w_code_nxt;
    logic [IDX_W-1:0]    r_sel;
    logic [IDX_W-1:0]    w_sel_nxt;
    logic [IDX_W-1:0]    r_rr_last;
    logic [IDX_W-1:0]    w_rr_nxt;
    logic [N_REQ-1:0]    r_pending;
    logic [N_REQ-1:0]    r_req_q;
    logic                r_lost;
    logic [N_REQ-1:0]    w_set;
    logic [N_REQ-1:0]    w_clr;
    logic                w_do_ack;
    logic                w_found;
    logic [IDX_W-1:0]    w_idx;

    assign w_set = (EDGE_MODE != 0) ? (i_req & ~r_req_q & i_mask) : (i_req & i_mask);

    prio_irq_encoder_pick #(.N_REQ(N_REQ)) u_pick (
        .i_vec       (r_pending & i_mask),
        .i_start_idx (r_rr_last),
        .i_rr_en     (RR_MODE != 0),
        .o_found     (w_found),
        .o_idx       (w_idx)
    );

    // Grant when idle and something is eligible; hold the grant until the consumer acks
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_code_nxt  = r_code;
        w_sel_nxt   = r_sel;
        w_rr_nxt    = r_rr_last;
        w_do_ack    = 1'b0;
        if (r_state == IDLE) begin
            if (w_found) begin
                w_state_nxt = PRESENT;
                w_valid_nxt = 1'b1;
                w_code_nxt  = CODE_W'(w_idx) + CODE_W'(1);
                w_sel_nxt   = w_idx;
            end
        end else if (i_irq_ack) begin
            w_do_ack    = 1'b1;
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
            w_code_nxt  = '0;
            w_rr_nxt    = r_sel;
        end
        w_clr = w_do_ack ? (N_REQ'(1) << r_sel) : '0;
    end

    // State, pending latches (set beats clear) and the lost-event pulse
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_valid   <= 1'b0;
            r_code    <= '0;
            r_sel     <= '0;
            r_rr_last <= '0;
            r_pending <= '0;
            r_req_q   <= '0;
            r_lost    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_valid   <= w_valid_nxt;
            r_code    <= w_code_nxt;
            r_sel     <= w_sel_nxt;
            r_rr_last <= w_rr_nxt;
            r_pending <= w_set | (r_pending & ~w_clr);
            r_req_q   <= i_req;
            r_lost    <= |(w_set & r_pending & ~w_clr);
        end
    end

    assign o_irq_valid = r_valid;
    assign o_irq_code  = r_code;
    assign o_pending   = r_pending;
    assign o_irq_lost  = r_lost;

endmodule

// File: tb/tb_prio_irq_encoder.sv
// tb_prio_irq_encoder: directed checks of fixed, round-robin and edge-mode encoders on shared stimulus
module tb_prio_irq_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;

    logic       valid_f, valid_r, valid_e;
    logic [3:0] code_f, code_r, code_e;
    logic [7:0] pend_f, pend_r, pend_e;
    logic       lost_f, lost_r, lost_e;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    prio_irq_encoder #(.N_REQ(8), .EDGE_MODE(0), .RR_MODE(0)) u_f (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_mask(mask), .i_irq_ack(ack),
        .o_irq_valid(valid_f), .o_irq_code(code_f), .o_pending(pend_f), .o_irq_lost(lost_f)
    );

    prio_irq_encoder #(.N_REQ(8), .EDGE_MODE(0), .RR_MODE(1)) u_r (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_mask(mask), .i_irq_ack(ack),
        .o_irq_valid(valid_r), .o_irq_code(code_r), .o_pending(pend_r), .o_irq_lost(lost_r)
    );

    prio_irq_encoder #(.N_REQ(8), .EDGE_MODE(1), .RR_MODE(0)) u_e (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_mask(mask), .i_irq_ack(ack),
        .o_irq_valid(valid_e), .o_irq_code(code_e), .o_pending(pend_e), .o_irq_lost(lost_e)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        mask  = 8'hFF;
        ack   = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        mask  = '0;
        ack   = 1'b0;
        cyc();
        cyc();
        chk("rst_valid", 32'(valid_f), 32'd0);
        chk("rst_code", 32'(code_f), 32'd0);
        chk("rst_pending", 32'(pend_f), 32'd0);
        chk("rst_lost", 32'(lost_f), 32'd0);

        // fixed priority: two lines, higher index first
        rst_n = 1'b1;
        mask  = 8'hFF;
        req   = 8'b0010_0100;
        cyc();
        req = '0;
        chk("t1_pending", 32'(pend_f), 32'h24);
        chk("t1_valid_lat", 32'(valid_f), 32'd0);
        cyc();
        chk("t1_valid", 32'(valid_f), 32'd1);
        chk("t1_code6", 32'(code_f), 32'd6);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("t1_bubble_valid", 32'(valid_f), 32'd0);
        chk("t1_bubble_code", 32'(code_f), 32'd0);
        chk("t1_pending_after", 32'(pend_f), 32'h04);
        cyc();
        chk("t1_code3", 32'(code_f), 32'd3);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("t1_pending_zero", 32'(pend_f), 32'd0);
        chk("t1_valid_zero", 32'(valid_f), 32'd0);

        // round robin with all lines held
        do_reset();
        req = 8'hFF;
        cyc();
        chk("t2_pending", 32'(pend_r), 32'hFF);
        cyc();
        chk("t2_lost", 32'(lost_r), 32'd1);
        for (int n = 0; n < 9; n++) begin
            chk($sformatf("t2_valid_%0d", n), 32'(valid_r), 32'd1);
            chk($sformatf("t2_code_%0d", n), 32'(code_r), (n == 8) ? 32'd8 : 32'(8 - n));
            ack = 1'b1;
            cyc();
            ack = 1'b0;
            chk($sformatf("t2_bubble_%0d", n), 32'(valid_r), 32'd0);
            cyc();
        end

        // edge mode: held request grants once, repeat pulse while pending is lost
        do_reset();
        cyc();
        req = 8'h08;
        cyc();
        chk("t3_pending", 32'(pend_e), 32'h08);
        chk("t3_lost0", 32'(lost_e), 32'd0);
        cyc();
        chk("t3_code4", 32'(code_e), 32'd4);
        for (int n = 0; n < 8; n++) begin
            cyc();
            chk($sformatf("t3_hold_code_%0d", n), 32'(code_e), 32'd4);
            chk($sformatf("t3_hold_lost_%0d", n), 32'(lost_e), 32'd0);
        end
        req = '0;
        cyc();
        req = 8'h08;
        cyc();
        req = '0;
        chk("t3_lost_pulse", 32'(lost_e), 32'd1);
        cyc();
        chk("t3_lost_clear", 32'(lost_e), 32'd0);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("t3_pending_zero", 32'(pend_e), 32'd0);
        cyc();
        chk("t3_no_regrant", 32'(valid_e), 32'd0);

        // mask: masked line neither sets nor wins; unmasking does not retract the grant
        do_reset();
        mask = 8'h7F;
        req  = 8'h82;
        cyc();
        req = '0;
        chk("t4_pending", 32'(pend_f), 32'h02);
        cyc();
        chk("t4_code2", 32'(code_f), 32'd2);
        mask = 8'hFF;
        req  = 8'h80;
        cyc();
        req = '0;
        chk("t4_hold_code", 32'(code_f), 32'd2);
        chk("t4_pending_both", 32'(pend_f), 32'h82);
        cyc();
        chk("t4_still_code2", 32'(code_f), 32'd2);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("t4_bubble", 32'(valid_f), 32'd0);
        cyc();
        chk("t4_code8", 32'(code_f), 32'd8);

        // set beats same-cycle ack clear
        do_reset();
        req = 8'h10;
        cyc();
        req = '0;
        cyc();
        chk("t5_code5", 32'(code_f), 32'd5);
        req = 8'h10;
        ack = 1'b1;
        cyc();
        req = '0;
        ack = 1'b0;
        chk("t5_pending_kept", 32'(pend_f), 32'h10);
        chk("t5_bubble", 32'(valid_f), 32'd0);
        chk("t5_lost", 32'(lost_f), 32'd0);
        cyc();
        chk("t5_regrant", 32'(code_f), 32'd5);
        chk("t5_regrant_valid", 32'(valid_f), 32'd1);

        // reset while presenting drops everything
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("t6_valid", 32'(valid_f), 32'd0);
        chk("t6_code", 32'(code_f), 32'd0);
        chk("t6_pending", 32'(pend_f), 32'd0);
        chk("t6_lost", 32'(lost_f), 32'd0);
        cyc();
        cyc();
        chk("t6_no_grant", 32'(valid_f), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
